// File: rtl/moore_detector.sv
// moore_detector: overlapping serial bit-pattern detector, Moore FSM with KMP-style fallback
module moore_detector #(
    parameter int                     PATTERN_LEN = 4,
    parameter logic [PATTERN_LEN-1:0] PATTERN     = 4'b1011,
    parameter int                     STATE_W     = $clog2(PATTERN_LEN + 1)
) (
    input  logic Clock,
    input  logic Reset,
    input  logic Din,
    output logic Y
);
    localparam logic [STATE_W-1:0] S0   = '0;
    localparam logic [STATE_W-1:0] SDET = STATE_W'(PATTERN_LEN);

    // Longest suffix of P[0..k-1],b that is also a prefix of P; P[0] is the PATTERN MSB
    function automatic logic [STATE_W-1:0] next_k(input int k, input logic b);
        logic [STATE_W-1:0]   r;
        logic [PATTERN_LEN-1:0] t;
        logic                 ok;
        logic                 sj;
        int                   j;
        r = S0;
        for (int l = 1; l <= PATTERN_LEN; l++) begin
            ok = (l <= k + 1);
            for (int i = 0; i < l; i++) begin
                j  = k + 1 - l + i;
                t  = PATTERN >> (PATTERN_LEN - 1 - j);
                sj = (j == k) ? b : t[0];
                t  = PATTERN >> (PATTERN_LEN - 1 - i);
                if (sj != t[0]) ok = 1'b0;
            end
            if (ok) r = STATE_W'(l);
        end
        return r;
    endfunction

    logic [STATE_W-1:0] state;
    logic [STATE_W-1:0] state_next;
    logic [STATE_W-1:0] nxt0 [2**STATE_W];
    logic [STATE_W-1:0] nxt1 [2**STATE_W];

    for (genvar k = 0; k < 2**STATE_W; k++) begin : g_tbl
        assign nxt0[k] = (k <= PATTERN_LEN) ? next_k(k, 1'b0) : S0;
        assign nxt1[k] = (k <= PATTERN_LEN) ? next_k(k, 1'b1) : S0;
    end

    // Transition lookup from the elaboration-time table
    always_comb begin
        state_next = Din ? nxt1[state] : nxt0[state];
    end

    // State register; reset wins over any Din value
    always_ff @(posedge Clock) begin
        if (Reset) state <= S0;
        else       state <= state_next;
    end

    assign Y = (state == SDET);
endmodule

// File: tb/tb_moore_detector.sv
// tb_moore_detector: table vectors, corner sequences and randomized checks against a history model
module tb_moore_detector;
    logic clk = 1'b0;
    logic Reset = 1'b1;
    logic Din = 1'b0;
    logic Y, Yb;
    int total = 0;
    int passed = 0;
    bit hist[$];

    always #5 clk = ~clk;

    moore_detector dut (.Clock(clk), .Reset(Reset), .Din(Din), .Y(Y));
    moore_detector #(.PATTERN_LEN(3), .PATTERN(3'b110)) dut_b (.Clock(clk), .Reset(Reset), .Din(Din), .Y(Yb));

    typedef struct {
        logic       rst;
        logic       din;
        logic [2:0] st;
        logic       y;
    } vec_t;
    vec_t tbl[28];

    task automatic chk(input string n, input int a, input int e);
        total++;
        if (a == e) passed++;
        else $display("FAIL %s: got %0d expected %0d at %0t", n, a, e, $time);
    endtask

    // Length of the longest suffix of the bits seen since reset that is a prefix of the pattern
    function automatic int ref_k(input logic [7:0] pat, input int n);
        logic [7:0] pv;
        int sz;
        bit ok;
        sz = hist.size();
        for (int l = (sz < n ? sz : n); l > 0; l--) begin
            ok = 1'b1;
            for (int i = 0; i < l; i++) begin
                pv = pat >> (n - 1 - i);
                if (hist[sz - l + i] != pv[0]) ok = 1'b0;
            end
            if (ok) return l;
        end
        return 0;
    endfunction

    task automatic step(input logic r, input logic d);
        @(negedge clk);
        Reset = r;
        Din = d;
        @(posedge clk);
        #1;
        if (r) hist.delete();
        else hist.push_back(d);
        chk("m1011_state", int'(dut.state), ref_k(8'b1011, 4));
        chk("m1011_y", int'(Y), int'(ref_k(8'b1011, 4) == 4));
        chk("m110_state", int'(dut_b.state), ref_k(8'b110, 3));
        chk("m110_y", int'(Yb), int'(ref_k(8'b110, 3) == 3));
    endtask

    initial begin
        tbl = '{
            '{1'b1, 1'bx, 3'd0, 1'b0},
            '{1'b1, 1'b1, 3'd0, 1'b0}, '{1'b1, 1'b1, 3'd0, 1'b0}, '{1'b1, 1'b1, 3'd0, 1'b0},
            '{1'b0, 1'b1, 3'd1, 1'b0}, '{1'b0, 1'b0, 3'd2, 1'b0}, '{1'b0, 1'b1, 3'd3, 1'b0},
            '{1'b0, 1'b1, 3'd4, 1'b1}, '{1'b0, 1'b0, 3'd2, 1'b0}, '{1'b0, 1'b1, 3'd3, 1'b0},
            '{1'b0, 1'b1, 3'd4, 1'b1}, '{1'b0, 1'b1, 3'd1, 1'b0}, '{1'b0, 1'b1, 3'd1, 1'b0},
            '{1'b1, 1'b0, 3'd0, 1'b0},
            '{1'b0, 1'b1, 3'd1, 1'b0}, '{1'b0, 1'b1, 3'd1, 1'b0}, '{1'b0, 1'b1, 3'd1, 1'b0},
            '{1'b0, 1'b1, 3'd1, 1'b0}, '{1'b0, 1'b0, 3'd2, 1'b0}, '{1'b0, 1'b0, 3'd0, 1'b0},
            '{1'b0, 1'b0, 3'd0, 1'b0}, '{1'b0, 1'b0, 3'd0, 1'b0},
            '{1'b1, 1'b0, 3'd0, 1'b0},
            '{1'b0, 1'b1, 3'd1, 1'b0}, '{1'b0, 1'b0, 3'd2, 1'b0}, '{1'b0, 1'b1, 3'd3, 1'b0},
            '{1'b1, 1'b1, 3'd0, 1'b0},
            '{1'b0, 1'b1, 3'd1, 1'b0}
        };
        foreach (tbl[i]) begin
            step(tbl[i].rst, tbl[i].din);
            chk($sformatf("tbl%0d_state", i), int'(dut.state), int'(tbl[i].st));
            chk($sformatf("tbl%0d_y", i), int'(Y), int'(tbl[i].y));
        end
        begin
            bit seq[7] = '{1, 1, 1, 0, 1, 1, 0};
            bit exp_y[7] = '{0, 0, 0, 1, 0, 0, 1};
            step(1'b1, 1'b0);
            foreach (seq[i]) begin
                step(1'b0, seq[i]);
                chk($sformatf("p110_edge%0d_y", i + 1), int'(Yb), int'(exp_y[i]));
            end
        end
        begin
            bit seq[7] = '{1, 0, 1, 1, 0, 1, 1};
            int hits = 0;
            step(1'b1, 1'b0);
            foreach (seq[i]) begin
                step(1'b0, seq[i]);
                hits += int'(Y);
            end
            chk("overlap_hits", hits, 2);
        end
        for (int n = 0; n < 2000; n++) step($urandom_range(31) == 0, 1'($urandom));
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/moore_detector.md
# moore_detector

Overlapping serial bit-pattern detector built as a Moore state machine. It samples one input bit per clock and raises a single-cycle output flag while the last `PATTERN_LEN` sampled bits equal `PATTERN`. The default pattern is 1011. The block sits on a serial data path as a standalone monitor; its output depends only on the registered state.

## Interface
Parameters:
- `PATTERN_LEN`, default 4: pattern length in bits, ≥1.
- `PATTERN`, default 4'b1011: pattern to detect; MSB is received first.
- `STATE_W`, default $clog2(PATTERN_LEN+1) (3 for the defaults): state register width.

Ports:
- `Clock`  input  1  single clock; all state changes on the rising edge.
- `Reset`  input  1  synchronous, active-high reset.
- `Din`  input  1  serial data bit, sampled on each rising edge of `Clock`.
- `Y`  output  1  detect flag; high while `state == PATTERN_LEN`.

Internal register `state` [STATE_W-1:0] must keep this exact name so that benches can probe it hierarchically as `dut.state`.

## Operation
- `state` encodes the matched-prefix length k, from 0 to `PATTERN_LEN`. States are S0..S`PATTERN_LEN`, with binary value equal to k.
- Next state from state k with input bit b:
  - form the string P[0..k-1] followed by b, where P[0] is `PATTERN` MSB;
  - next k' is the length of the longest suffix of that string which is also a proper-or-full prefix of P, capped at `PATTERN_LEN`.
  - This gives overlapping detection with KMP-style fallback.
- The transition table may be computed at elaboration (generate/function) or written out. It must be correct for any legal `PATTERN`/`PATTERN_LEN`.
- Default pattern 1011, required transitions (Din=0 / Din=1):
  - S0 → S0 / S1
  - S1 → S2 / S1
  - S2 → S0 / S3
  - S3 → S2 / S4
  - S4 → S2 / S1
- `Y` = (`state` == `PATTERN_LEN`). It is a decode of the registered state only, with no combinational path from `Din`.
- Overlapping matches are detected. With the default pattern, 1011011 produces two detections.
- X on `Din` while `Reset` is high must not corrupt `state`.

## Timing
- Reset: on a rising edge with `Reset`=1, `state` ← 0, regardless of `Din` or current state. `Y` is 0 from that edge.
- `Reset` has priority over `Din` at every edge.
- Reset asserted mid-match discards the partial match. The first edge after reset deassertion is evaluated from S0.
- Latency: `Y` rises on the same rising edge that samples the final pattern bit, i.e. it is visible in the cycle after that bit is presented. `Y` lasts exactly one cycle unless the next bit completes another overlapping match.
- Back-to-back matches are only possible when the pattern overlaps itself. 1111 with the default pattern never asserts `Y`.
- No handshake. One bit is consumed every cycle.

## Test plan
- Reset: hold `Reset`=1 for one edge with `Din`=X → `state`=0, `Y`=0. Hold `Reset` for several edges with `Din`=1 → `state` stays 0.
- Basic detect: after reset, drive `Din` 1,0,1,1 on successive edges → `state` sequence 1,2,3,4; `Y`=1 only after the 4th edge.
- Overlap and fallback: after reset, drive 1,0,1,1,0,1,1,1,1 →
  - `state` 1,2,3,4,2,3,4,1,1;
  - `Y` high after edges 4 and 7 only.
- No false hits: drive 1,1,1,1,0,0,0,0 → `Y` never asserts; `state` ends at 0.
- Reset mid-match: drive 1,0,1, then assert `Reset` for one edge, then drive 1 → `state` 0 then 1; `Y` stays 0.
- Parameter check: `PATTERN_LEN`=3, `PATTERN`=3'b110, drive 1,1,1,0,1,1,0 → `Y` high after edges 4 and 7.
